frame_sync: RTL

Byte-stream frame aligner for the MP3 decode path. It sits directly upstream of `header` and consumes the raw byte stream from the file/SD source. It hunts for the MPEG-1 Layer III sync pattern and discards bytes until a frame start is found. It then forwards frame-aligned bytes with a start-of-frame flag, and uses the frame length computed by `header` to check that the next sync word lands exactly where predicted.

---
 rtl/frame_sync.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/frame_sync.sv
// MPEG-1 Layer III byte-stream frame aligner: hunts for FF FA/FB, forwards frame-aligned bytes
// with a one-byte lag, and checks that each next sync word lands where the header length says.
module frame_sync #(
   parameter int unsigned MAX_FRAME = 2047
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  axiid,
   input  logic        axiiv,
   input  logic [10:0] frame_size,
   input  logic        frame_size_valid,
   output logic [7:0]  axiod,
   output logic        axiov,
   output logic        sof,
   output logic        locked,
   output logic        sync_err
);

   localparam logic [1:0] StHunt   = 2'd0;
   localparam logic [1:0] StSync1  = 2'd1;
   localparam logic [1:0] StFrame  = 2'd2;
   localparam logic [1:0] StCheck2 = 2'd3;

   localparam logic [10:0] MaxCnt = 11'(MAX_FRAME);

   logic [1:0]  state_q, state_d;
   logic [7:0]  held_q, held_d;
   logic [10:0] cnt_q, cnt_d;
   logic [10:0] len_q, len_d;
   logic        len_v_q, len_v_d;
   logic [7:0]  dout_q, dout_d;
   logic        vout_q, vout_d;
   logic        sof_q, sof_d;
   logic        lock_q, lock_d;
   logic        err_q, err_d;

   logic is_ff, is_sync2, timeout, bad_size;

   always_comb begin
      is_ff    = (axiid == 8'hFF);
      is_sync2 = (axiid == 8'hFA) || (axiid == 8'hFB);
      timeout  = (state_q == StFrame) && !len_v_q && (cnt_q == MaxCnt);
      bad_size = (state_q == StFrame) && frame_size_valid && (frame_size < 11'd4);
   end

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      len_v_d = len_v_q;
      dout_d  = dout_q;
      vout_d  = 1'b0;
      sof_d   = 1'b0;
      lock_d  = lock_q;
      err_d   = 1'b0;

      // Abort conditions win over any byte accepted in the same cycle.
      if (timeout || bad_size) begin
         state_d = StHunt;
         err_d   = 1'b1;
         lock_d  = 1'b0;
      end else begin
         // New length takes effect next cycle; this cycle's byte sees the old one.
         if (state_q == StFrame && frame_size_valid) begin
            len_d   = frame_size;
            len_v_d = 1'b1;
         end
         if (axiiv) begin
            unique case (state_q)
               StHunt: begin
                  if (is_ff) begin
                     held_d  = axiid;
                     state_d = StSync1;
                  end
               end
               StSync1: begin
                  if (is_sync2) begin
                     dout_d  = held_q;
                     vout_d  = 1'b1;
                     sof_d   = 1'b1;
                     held_d  = axiid;
                     cnt_d   = 11'd2;
                     len_v_d = 1'b0;
                     state_d = StFrame;
                  end else if (is_ff) begin
                     held_d = axiid;
                  end else begin
                     state_d = StHunt;
                  end
               end
               StFrame: begin
                  dout_d = held_q;
                  vout_d = 1'b1;
                  // cnt beyond len means the length arrived late: treat as misalignment.
                  if (len_v_q && cnt_q >= len_q) begin
                     if (cnt_q == len_q && is_ff) begin
                        held_d  = axiid;
                        state_d = StCheck2;
                     end else begin
                        err_d   = 1'b1;
                        lock_d  = 1'b0;
                        state_d = StHunt;
                     end
                  end else begin
                     held_d = axiid;
                     cnt_d  = cnt_q + 11'd1;
                  end
               end
               StCheck2: begin
                  if (is_sync2) begin
                     dout_d  = held_q;
                     vout_d  = 1'b1;
                     sof_d   = 1'b1;
                     held_d  = axiid;
                     cnt_d   = 11'd2;
                     len_v_d = 1'b0;
                     lock_d  = 1'b1;
                     state_d = StFrame;
                  end else begin
                     err_d  = 1'b1;
                     lock_d = 1'b0;
                     if (is_ff) begin
                        held_d  = axiid;
                        state_d = StSync1;
                     end else begin
                        state_d = StHunt;
                     end
                  end
               end
               default: state_d = StHunt;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StHunt;
         held_q  <= 8'h00;
         cnt_q   <= 11'd0;
         len_q   <= 11'd0;
         len_v_q <= 1'b0;
         dout_q  <= 8'h00;
         vout_q  <= 1'b0;
         sof_q   <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         len_v_q <= len_v_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
         sof_q   <= sof_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   assign axiod    = dout_q;
   assign axiov    = vout_q;
   assign sof      = sof_q;
   assign locked   = lock_q;
   assign sync_err = err_q;

endmodule
